// File: rtl/priority_scan_encoder.sv
// Accepts a WIDTH-bit request vector and emits the index of every set bit,
// one per beat, lowest-first or highest-first as chosen when the vector is taken.
module priority_scan_encoder #(
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_found,
  output logic             out_last
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic             mode;

  logic [IDXW-1:0]  lo_idx, hi_idx, sel_idx;
  logic [WIDTH-1:0] clr_mask;
  logic             rem_any, rem_one_or_less;

  // Both scans only walk real bit positions, so codes >= WIDTH cannot appear.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (rem[i]) lo_idx = IDXW'(i);
    for (int i = 0; i < WIDTH; i++)
      if (rem[i]) hi_idx = IDXW'(i);
  end

  assign sel_idx         = mode ? hi_idx : lo_idx;
  assign rem_any         = |rem;
  assign rem_one_or_less = ((rem & (rem - WIDTH'(1))) == '0);

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < WIDTH; i++)
      clr_mask[i] = (IDXW'(i) == sel_idx);
  end

  // Outputs decode only from registered state; no input reaches them directly.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SCAN);
  assign out_found = out_valid & rem_any;
  assign out_last  = out_valid & rem_one_or_less;
  assign out_idx   = out_valid ? sel_idx : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rem   <= in_vec;
          mode  <= in_mode;
          state <= SCAN;
        end
        SCAN: if (out_ready) begin
          rem <= rem & ~clr_mask;
          if (rem_one_or_less) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Bench for priority_scan_encoder: directed table, reset corner cases, random
// vectors against a set-bit list model, and a WIDTH=5 instance.
module tb_priority_scan_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_found, out_last;
  logic [7:0] in_vec;
  logic [2:0] out_idx;

  logic       in_valid5, in_ready5, in_mode5, out_valid5, out_ready5, out_found5, out_last5;
  logic [4:0] in_vec5;
  logic [2:0] out_idx5;

  int n_cmp = 0;
  int n_bad = 0;
  int eq[$];

  always #5 clk = ~clk;

  priority_scan_encoder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_found(out_found),
    .out_last(out_last));

  priority_scan_encoder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_vec(in_vec5), .in_mode(in_mode5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_idx(out_idx5), .out_found(out_found5),
    .out_last(out_last5));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected beats come from eq: an index, or -1 for the all-zero beat.
  // Entered and left at a negedge with the DUT idle.
  task automatic run8(input logic [7:0] v, input bit m, input int hold0, input bit rnd);
    int k = 0;
    int stalls = 0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    in_valid = 1'b1; in_vec = v; in_mode = m; out_ready = 1'b1;
    @(negedge clk);
    while (k < eq.size()) begin
      in_valid = 1'($urandom); in_vec = 8'($urandom); in_mode = 1'($urandom);
      if (k == 0 && stalls < hold0)  out_ready = 1'b0;
      else if (rnd && stalls < 3)    out_ready = 1'($urandom_range(0, 1));
      else                           out_ready = 1'b1;
      chk("out_valid", out_valid, 1);
      chk("busy_in_ready", in_ready, 0);
      chk("out_idx", out_idx, (eq[k] < 0) ? 0 : eq[k]);
      chk("out_found", out_found, (eq[k] >= 0) ? 1 : 0);
      chk("out_last", out_last, (k == eq.size() - 1) ? 1 : 0);
      @(negedge clk);
      if (out_ready) begin k++; stalls = 0; end
      else stalls++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("done_in_ready", in_ready, 1);
    chk("done_out_valid", out_valid, 0);
  endtask

  task automatic model(input logic [7:0] v, input bit m, input int w);
    eq.delete();
    for (int i = 0; i < w; i++)
      if (v[i]) begin
        if (m) eq.push_front(i);
        else   eq.push_back(i);
      end
    if (eq.size() == 0) eq.push_back(-1);
  endtask

  task automatic run5(input logic [4:0] v, input bit m);
    model({3'b000, v}, m, 5);
    in_valid5 = 1'b1; in_vec5 = v; in_mode5 = m;
    @(negedge clk);
    in_valid5 = 1'b0;
    for (int k = 0; k < eq.size(); k++) begin
      chk("w5_out_valid", out_valid5, 1);
      chk("w5_out_idx", out_idx5, (eq[k] < 0) ? 0 : eq[k]);
      chk("w5_idx_range", (out_idx5 < 3'd5) ? 1 : 0, 1);
      chk("w5_out_found", out_found5, (eq[k] >= 0) ? 1 : 0);
      chk("w5_out_last", out_last5, (k == eq.size() - 1) ? 1 : 0);
      @(negedge clk);
    end
    chk("w5_done_in_ready", in_ready5, 1);
  endtask

  typedef struct {
    logic [7:0]  vec;
    bit          mode;
    int          hold;
    int          n;     // beats with a real index; 0 means all-zero vector
    logic [31:0] seq;   // nibble k = index of beat k
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'hA4, 1'b0, 0, 3, 32'h0000_0752};
    tbl[1] = '{8'hA4, 1'b1, 0, 3, 32'h0000_0257};
    tbl[2] = '{8'h00, 1'b0, 0, 0, 32'h0};
    tbl[3] = '{8'h81, 1'b0, 3, 2, 32'h0000_0070};
    tbl[4] = '{8'h10, 1'b1, 0, 1, 32'h0000_0004};
    tbl[5] = '{8'h01, 1'b1, 2, 1, 32'h0000_0000};
    tbl[6] = '{8'h80, 1'b0, 0, 1, 32'h0000_0007};
    tbl[7] = '{8'hFF, 1'b0, 0, 8, 32'h7654_3210};
    tbl[8] = '{8'h00, 1'b1, 4, 0, 32'h0};

    rst = 1'b1;
    in_valid = 1'b0; in_vec = '0; in_mode = 1'b0; out_ready = 1'b1;
    in_valid5 = 1'b0; in_vec5 = '0; in_mode5 = 1'b0; out_ready5 = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_found", out_found, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[t]) begin
      logic [31:0] s;
      s = tbl[t].seq;
      eq.delete();
      if (tbl[t].n == 0) eq.push_back(-1);
      for (int k = 0; k < tbl[t].n; k++) eq.push_back(int'(s[4*k +: 4]));
      run8(tbl[t].vec, tbl[t].mode, tbl[t].hold, 1'b0);
    end

    // Asynchronous reset after three beats of 8'hFF, MSB-first.
    in_valid = 1'b1; in_vec = 8'hFF; in_mode = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_pre_idx", out_idx, 7 - k);
      @(negedge clk);
    end
    chk("abort_next_idx", out_idx, 4);
    chk("abort_next_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_idx", out_idx, 0);
    in_valid = 1'b1; in_vec = 8'h3C;   // offered while in reset, must be dropped
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    chk("post_rst_out_valid", out_valid, 0);
    @(negedge clk);
    chk("no_resume_out_valid", out_valid, 0);
    chk("no_resume_in_ready", in_ready, 1);
    eq.delete(); eq.push_back(4);
    run8(8'h10, 1'b0, 0, 1'b0);

    for (int r = 0; r < 60; r++) begin
      logic [7:0] v;
      bit m;
      v = 8'($urandom);
      if (r % 3 == 0) v = v & 8'($urandom);
      if (r % 11 == 0) v = 8'h00;
      m = 1'($urandom);
      model(v, m, 8);
      run8(v, m, 0, 1'b1);
    end

    run5(5'b10001, 1'b1);
    run5(5'b00000, 1'b0);
    run5(5'b11111, 1'b1);
    for (int r = 0; r < 20; r++) run5(5'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
- Parametrised, sequential successor to the 4-bit combinational LSB/MSB priority encoder.
- Accepts a WIDTH-bit request vector through a valid/ready handshake.
- Emits the index of every set bit, one per output beat, in LSB-first or MSB-first order selected per vector.
- Sits between request-collection logic (interrupt or flag registers) and a downstream consumer that services one index at a time.

Parameters:
- WIDTH, 8, number of request bits; any value >= 2, power of two not required.
- IDXW, $clog2(WIDTH), width of the emitted index; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_vec/in_mode present.
- in_ready  output  1  block can accept a new vector.
- in_vec  input  WIDTH  request vector.
- in_mode  input  1  0 = LSB-first (lowest set bit first), 1 = MSB-first.
- out_valid  output  1  out_idx/out_found/out_last valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IDXW  index of the current set bit; 0 when out_found=0.
- out_found  output  1  1 = out_idx is a real set bit; 0 = vector was all-zero.
- out_last  output  1  final beat for this vector.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst=1, independent of clk):
  - state=IDLE, remaining vector register=0, mode register=0.
  - in_ready=1, out_valid=0, out_idx=0, out_found=0, out_last=0.
- No combinational path from in_* or out_ready to any output. All outputs decode from state, remaining-vector and mode registers only.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at a clock edge: latch in_vec into the remaining register, latch in_mode, go to SCAN.
- SCAN:
  - in_ready=0; in_valid, in_vec and in_mode are ignored.
  - out_valid=1.
  - out_idx = lowest set bit of the remaining register (mode 0) or highest set bit (mode 1).
  - out_found=1 if the remaining register is nonzero.
  - out_last=1 when the remaining register has exactly one bit set, or is zero.
- Beat transfer happens on out_valid & out_ready at a clock edge:
  - Clear bit out_idx in the remaining register.
  - If out_last=1, return to IDLE; in_ready=1 in the following cycle.
- Backpressure: while out_ready=0, out_idx, out_found and out_last hold stable and out_valid stays 1. out_valid is never withdrawn before transfer.
- All-zero vector: exactly one beat, out_found=0, out_idx=0, out_last=1.
- Latency and throughput:
  - First beat is valid in the cycle after acceptance.
  - A vector with N set bits takes N beats (1 beat if N=0) at 1 beat/cycle when out_ready=1.
  - One idle/accept cycle follows between vectors. No back-to-back acceptance on the last beat.
- Index arithmetic:
  - out_idx is unsigned, range 0..WIDTH-1.
  - For non-power-of-two WIDTH, unused codes never appear.
  - Bits of in_vec above WIDTH-1 do not exist; no padding is interpreted.
- Mode is fixed per vector. in_mode changes during SCAN have no effect.
- Reset mid-scan: the vector is aborted, out_valid drops immediately, and no partial beats resume after rst deasserts.
- Simultaneous in_valid and rst: rst wins, nothing is captured.

Test Plan:
1. WIDTH=8, in_vec=8'b1010_0100, in_mode=0, out_ready=1, accepted at cycle t -> beats at t+1..t+3 with out_idx=2,5,7, out_found=1, out_last only on idx 7; in_ready=1 at t+4.
2. Same vector, in_mode=1 -> out_idx=7,5,2; out_last on idx 2.
3. in_vec=8'h00 -> single beat: out_found=0, out_idx=0, out_last=1; in_ready=1 next cycle.
4. in_vec=8'h81, in_mode=0, out_ready=0 for 3 cycles after out_valid rises; toggle in_vec/in_mode/in_valid meanwhile -> out_idx=0 held stable with out_valid=1 throughout; then out_idx=0, 7 are transferred; in_ready stays 0 until after idx 7.
5. in_vec=8'hFF, in_mode=1; assert rst asynchronously after 3 transferred beats (7,6,5) -> out_valid=0 and in_ready=1 without a clock edge; after release, in_vec=8'h10 -> single beat out_idx=4, out_last=1.
6. WIDTH=5 instance, in_vec=5'b10001, in_mode=1 -> out_idx=4 then 0, IDXW=3, no code above 4 ever driven.
